// File: rtl/bmp_pkg.sv
// Shared BMP file-format constants, loader state encoding and helpers.
// Used by both the load (bmp_read) and save paths.
package bmp_pkg;

  localparam int HEADER_SIZE  = 54;
  localparam int BPP          = 24;
  localparam int SECTOR_BYTES = 512;

  localparam logic [21:0] OFS_SIG      = 22'd0;
  localparam logic [21:0] OFS_DATA_OFS = 22'd10;
  localparam logic [21:0] OFS_WIDTH    = 22'd18;
  localparam logic [21:0] OFS_HEIGHT   = 22'd22;
  localparam logic [21:0] OFS_BPP      = 22'd28;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WAIT_END,
    S_END,
    S_ERR
  } state_t;

  function automatic logic [7:0] le_byte(
    input logic [31:0] v,
    input logic [1:0]  idx
  );
    return v[{idx, 3'b000} +: 8];
  endfunction

  // True when byte d at header offset ofs is acceptable
  function automatic logic hdr_byte_ok(
    input logic [21:0] ofs,
    input logic [7:0]  d,
    input logic [31:0] w,
    input logic [31:0] h
  );
    logic       chk;
    logic [7:0] exp;
    chk = 1'b1;
    exp = 8'h00;
    unique case (1'b1)
      ofs == OFS_SIG:
        exp = 8'h42;
      ofs == OFS_SIG + 22'd1:
        exp = 8'h4D;
      (ofs >= OFS_DATA_OFS) && (ofs < OFS_DATA_OFS + 22'd4):
        exp = le_byte(32'(HEADER_SIZE), 2'(ofs - OFS_DATA_OFS));
      (ofs >= OFS_WIDTH) && (ofs < OFS_WIDTH + 22'd4):
        exp = le_byte(w, 2'(ofs - OFS_WIDTH));
      (ofs >= OFS_HEIGHT) && (ofs < OFS_HEIGHT + 22'd4):
        exp = le_byte(h, 2'(ofs - OFS_HEIGHT));
      ofs == OFS_BPP:
        exp = 8'(BPP);
      ofs == OFS_BPP + 22'd1:
        exp = 8'h00;
      default:
        chk = 1'b0;
    endcase
    return !chk || (d == exp);
  endfunction

  function automatic logic [15:0] rgb565(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/bmp_pixel_pack.sv
// Groups the B,G,R byte stream into RGB565 words.
// The phase survives sector boundaries; only clr resets it.
module bmp_pixel_pack
  import bmp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic        r_phase,
  output logic [15:0] photo_data,
  output logic        photo_wr
);

  logic [1:0] phase;
  logic [7:0] b_lat;
  logic [7:0] g_lat;

  assign r_phase = (phase == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= 2'd0;
      b_lat      <= 8'h00;
      g_lat      <= 8'h00;
      photo_data <= 16'h0000;
      photo_wr   <= 1'b0;
    end else begin
      photo_wr <= 1'b0;
      if (clr) begin
        phase <= 2'd0;
      end else if (en) begin
        unique case (phase)
          2'd0: begin
            b_lat <= data;
            phase <= 2'd1;
          end
          2'd1: begin
            g_lat <= data;
            phase <= 2'd2;
          end
          default: begin
            photo_data <= rgb565(data, g_lat, b_lat);
            photo_wr   <= 1'b1;
            phase      <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/bmp_read.sv
// Loads a 24-bit BMP from consecutive SD sectors, checks the header
// and streams RGB565 pixels into the frame-buffer write path.
module bmp_read
  import bmp_pkg::*;
#(
  parameter int START_SECTOR = 32000,
  parameter int IMG_WIDTH    = 1024,
  parameter int IMG_HEIGHT   = 768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        photo_load,
  input  logic        sd_init_done,
  output logic        sd_sec_read,
  output logic [31:0] sd_sec_read_addr,
  input  logic [7:0]  sd_sec_read_data,
  input  logic        sd_sec_read_data_valid,
  input  logic        sd_sec_read_end,
  output logic        write_req,
  input  logic        write_req_ack,
  output logic [15:0] photo_data,
  output logic        photo_wr,
  output logic        loaded,
  output logic        load_err
);

  localparam logic [31:0] START_ADDR = 32'(START_SECTOR);
  localparam logic [31:0] W32        = 32'(IMG_WIDTH);
  localparam logic [31:0] H32        = 32'(IMG_HEIGHT);
  localparam logic [31:0] NPIX       = 32'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [21:0] HDR_LAST   = 22'(HEADER_SIZE - 1);
  localparam logic [21:0] HDR_SZ     = 22'(HEADER_SIZE);

  state_t      state;
  logic [21:0] byte_cnt;
  logic [31:0] pix_cnt;
  logic        hdr_bad;
  logic        err_pending;

  logic byte_v;
  logic is_pix;
  logic pix_en;
  logic pack_clr;
  logic r_phase;
  logic hdr_ok_now;
  logic hdr_fail;
  logic last_pix;

  assign byte_v     = (state == S_READ) && sd_sec_read_data_valid;
  assign is_pix     = (byte_cnt >= HDR_SZ);
  assign pix_en     = byte_v && is_pix && sd_init_done;
  assign pack_clr   = !sd_init_done || ((state == S_IDLE) && photo_load);
  assign hdr_ok_now = hdr_byte_ok(byte_cnt, sd_sec_read_data, W32, H32);
  assign hdr_fail   = byte_v && (byte_cnt == HDR_LAST)
                      && (hdr_bad || !hdr_ok_now);
  assign last_pix   = pix_en && r_phase && (pix_cnt == NPIX - 32'd1);

  bmp_pixel_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .clr        (pack_clr),
    .en         (pix_en),
    .data       (sd_sec_read_data),
    .r_phase    (r_phase),
    .photo_data (photo_data),
    .photo_wr   (photo_wr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      sd_sec_read      <= 1'b0;
      sd_sec_read_addr <= START_ADDR;
      write_req        <= 1'b0;
      loaded           <= 1'b0;
      load_err         <= 1'b0;
      byte_cnt         <= 22'd0;
      pix_cnt          <= 32'd0;
      hdr_bad          <= 1'b0;
      err_pending      <= 1'b0;
    end else begin
      loaded   <= 1'b0;
      load_err <= 1'b0;
      if (!sd_init_done) begin
        state       <= S_IDLE;
        sd_sec_read <= 1'b0;
        write_req   <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (photo_load) begin
              state            <= S_REQ;
              sd_sec_read_addr <= START_ADDR;
              byte_cnt         <= 22'd0;
              pix_cnt          <= 32'd0;
              hdr_bad          <= 1'b0;
              err_pending      <= 1'b0;
              write_req        <= 1'b1;
            end
          end
          S_REQ: begin
            if (write_req_ack) begin
              write_req   <= 1'b0;
              sd_sec_read <= 1'b1;
              state       <= S_READ;
            end
          end
          S_READ: begin
            if (byte_v) begin
              byte_cnt <= byte_cnt + 22'd1;
              if (!is_pix && !hdr_ok_now)
                hdr_bad <= 1'b1;
            end
            if (pix_en && r_phase)
              pix_cnt <= pix_cnt + 32'd1;
            if (hdr_fail)
              err_pending <= 1'b1;
            // The byte is consumed before the sector boundary is handled
            if (hdr_fail || last_pix) begin
              if (sd_sec_read_end) begin
                sd_sec_read <= 1'b0;
                state       <= hdr_fail ? S_ERR : S_END;
              end else begin
                sd_sec_read <= 1'b1;
                state       <= S_WAIT_END;
              end
            end else if (sd_sec_read_end) begin
              sd_sec_read      <= 1'b0;
              sd_sec_read_addr <= sd_sec_read_addr + 32'd1;
            end else begin
              sd_sec_read <= 1'b1;
            end
          end
          S_WAIT_END: begin
            if (sd_sec_read_end) begin
              sd_sec_read <= 1'b0;
              state       <= err_pending ? S_ERR : S_END;
            end else begin
              sd_sec_read <= 1'b1;
            end
          end
          S_END: begin
            loaded <= 1'b1;
            state  <= S_IDLE;
          end
          S_ERR: begin
            load_err <= 1'b1;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bmp_read.sv
// Directed bench for bmp_read with a small 160x2 image so that the
// pixel stream spans two sectors and a triplet straddles 511/512.
module tb_bmp_read;

  localparam int START = 100;
  localparam int W     = 160;
  localparam int H     = 2;
  localparam int NPIX  = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        photo_load;
  logic        sd_init_done;
  logic        sd_sec_read;
  logic [31:0] sd_sec_read_addr;
  logic [7:0]  sd_sec_read_data;
  logic        sd_sec_read_data_valid;
  logic        sd_sec_read_end;
  logic        write_req;
  logic        write_req_ack;
  logic [15:0] photo_data;
  logic        photo_wr;
  logic        loaded;
  logic        load_err;

  int n_chk  = 0;
  int n_fail = 0;
  int n_loaded = 0;
  int n_err    = 0;
  logic [15:0] pixq[$];
  logic [31:0] sec_addrs[$];

  bmp_read #(
    .START_SECTOR (START),
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .photo_load             (photo_load),
    .sd_init_done           (sd_init_done),
    .sd_sec_read            (sd_sec_read),
    .sd_sec_read_addr       (sd_sec_read_addr),
    .sd_sec_read_data       (sd_sec_read_data),
    .sd_sec_read_data_valid (sd_sec_read_data_valid),
    .sd_sec_read_end        (sd_sec_read_end),
    .write_req              (write_req),
    .write_req_ack          (write_req_ack),
    .photo_data             (photo_data),
    .photo_wr               (photo_wr),
    .loaded                 (loaded),
    .load_err               (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (photo_wr) pixq.push_back(photo_data);
    if (loaded) n_loaded++;
    if (load_err) n_err++;
  end

  // mode 0: valid file, 1: bad signature byte, 2: height field 600
  function automatic logic [7:0] file_byte(input int ofs, input int mode);
    int v, p, k, c;
    if (ofs < 54) begin
      v = 0;
      if (ofs == 0) v = 66;
      else if (ofs == 1) v = (mode == 1) ? 88 : 77;
      else if (ofs == 10) v = 54;
      else if (ofs >= 18 && ofs < 22) v = (W >> (8 * (ofs - 18))) & 255;
      else if (ofs >= 22 && ofs < 26)
        v = (((mode == 2) ? 600 : H) >> (8 * (ofs - 22))) & 255;
      else if (ofs == 26) v = 1;
      else if (ofs == 28) v = 24;
      return 8'(v);
    end
    if (ofs >= 54 + 3 * NPIX) return 8'hAA;
    p = ofs - 54;
    k = p / 3;
    c = p % 3;
    if (k == 0) return (c == 1) ? 8'h00 : 8'hFF;
    return 8'(k * 37 + c * 91 + 5);
  endfunction

  function automatic logic [15:0] exp_pix(input int k);
    logic [7:0] b, g, r;
    b = file_byte(54 + 3 * k, 0);
    g = file_byte(55 + 3 * k, 0);
    r = file_byte(56 + 3 * k, 0);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  task automatic start_load(input int ack_delay, output bit got);
    got = 1'b0;
    @(posedge clk); #1 photo_load = 1'b1;
    @(posedge clk); #1 photo_load = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (write_req) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) return;
    repeat (ack_delay) @(negedge clk);
    @(posedge clk); #1 write_req_ack = 1'b1;
    @(posedge clk); #1 write_req_ack = 1'b0;
  endtask

  // Sector-read model; the last byte of every sector carries end
  task automatic serve(input int nsec, input int mode, input int stop_at,
                       output int served);
    int off, bad;
    bit ok;
    logic [31:0] a0;
    served = 0;
    off = 0;
    for (int s = 0; s < nsec; s++) begin
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (sd_sec_read) begin ok = 1'b1; break; end
      end
      if (!ok) return;
      a0 = sd_sec_read_addr;
      sec_addrs.push_back(a0);
      bad = 0;
      for (int i = 0; i < 512; i++) begin
        if (i % 64 == 63) begin
          @(posedge clk); #1;
          sd_sec_read_data_valid = 1'b0;
        end
        @(posedge clk); #1;
        if (off == stop_at) begin
          sd_sec_read_data_valid = 1'b0;
          sd_sec_read_end = 1'b0;
          sd_init_done = 1'b0;
          return;
        end
        sd_sec_read_data = file_byte(off, mode);
        sd_sec_read_data_valid = 1'b1;
        sd_sec_read_end = (i == 511);
        off++;
        @(negedge clk);
        if (sd_sec_read_addr !== a0 || sd_sec_read !== 1'b1) bad++;
      end
      @(posedge clk); #1;
      sd_sec_read_data_valid = 1'b0;
      sd_sec_read_end = 1'b0;
      @(negedge clk);
      n_chk++;
      if (sd_sec_read !== 1'b0) begin
        n_fail++;
        $display("FAIL sec_read_gap sector %0d: got %b want 0", s, sd_sec_read);
      end
      n_chk++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL addr_hold sector %0d: %0d bad cycles, want 0", s, bad);
      end
      served++;
    end
  endtask

  task automatic clear_obs();
    pixq.delete();
    sec_addrs.delete();
    n_loaded = 0;
    n_err = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    photo_load = 1'b0;
    sd_init_done = 1'b0;
    sd_sec_read_data = 8'h00;
    sd_sec_read_data_valid = 1'b0;
    sd_sec_read_end = 1'b0;
    write_req_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (sd_sec_read !== 1'b0 || write_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req: read=%b wreq=%b want 0 0", sd_sec_read, write_req);
    end
    n_chk++;
    if (sd_sec_read_addr !== 32'(START)) begin
      n_fail++;
      $display("FAIL reset_addr: got %0d want %0d", sd_sec_read_addr, START);
    end
    n_chk++;
    if (photo_data !== 16'h0 || photo_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pix: data=%h wr=%b want 0 0", photo_data, photo_wr);
    end
    n_chk++;
    if (loaded !== 1'b0 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: loaded=%b err=%b want 0 0", loaded, load_err);
    end
    rst = 1'b0;
    sd_init_done = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_image(input string tag);
    int bad;
    n_chk++;
    if (pixq.size() != NPIX) begin
      n_fail++;
      $display("FAIL %s pix_count: got %0d want %0d", tag, pixq.size(), NPIX);
    end
    n_chk++;
    if (pixq.size() < 1 || pixq[0] !== 16'hF81F) begin
      n_fail++;
      $display("FAIL %s first_pix: got %h want f81f",
               tag, (pixq.size() > 0) ? pixq[0] : 16'hxxxx);
    end
    bad = 0;
    for (int k = 0; k < pixq.size() && k < NPIX; k++)
      if (pixq[k] !== exp_pix(k)) bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s pix_data: %0d wrong words, want 0", tag, bad);
    end
    n_chk++;
    if (n_loaded != 1 || n_err != 0) begin
      n_fail++;
      $display("FAIL %s done_pulse: loaded=%0d err=%0d want 1 0",
               tag, n_loaded, n_err);
    end
  endtask

  task automatic test_valid_image();
    bit got;
    int served;
    clear_obs();
    start_load(3, got);
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL valid write_req: got 0 want 1");
    end
    serve(2, 0, -1, served);
    repeat (10) @(negedge clk);
    n_chk++;
    if (served != 2 || sec_addrs.size() != 2) begin
      n_fail++;
      $display("FAIL valid sectors: got %0d want 2", served);
    end else begin
      n_chk++;
      if (sec_addrs[0] !== 32'(START) || sec_addrs[1] !== 32'(START + 1)) begin
        n_fail++;
        $display("FAIL valid sec_addr: got %0d,%0d want %0d,%0d",
                 sec_addrs[0], sec_addrs[1], START, START + 1);
      end
    end
    check_image("valid");
    // B at 510, G at 511 with end, R at 512 in the next sector
    n_chk++;
    if (pixq.size() < 153 || pixq[152] !== 16'hB2DF) begin
      n_fail++;
      $display("FAIL straddle_pix: got %h want b2df",
               (pixq.size() > 152) ? pixq[152] : 16'hxxxx);
    end
  endtask

  task automatic test_bad_header(input int mode, input string tag);
    bit got;
    int served;
    clear_obs();
    start_load(3, got);
    n_chk++;
    if (!got || sd_sec_read_addr !== 32'(START)) begin
      n_fail++;
      $display("FAIL %s start: req=%b addr=%0d want 1 %0d",
               tag, got, sd_sec_read_addr, START);
    end
    serve(1, mode, -1, served);
    repeat (10) @(negedge clk);
    n_chk++;
    if (served != 1) begin
      n_fail++;
      $display("FAIL %s sectors: got %0d want 1", tag, served);
    end
    n_chk++;
    if (pixq.size() != 0) begin
      n_fail++;
      $display("FAIL %s pix_count: got %0d want 0", tag, pixq.size());
    end
    n_chk++;
    if (n_err != 1 || n_loaded != 0) begin
      n_fail++;
      $display("FAIL %s err_pulse: err=%0d loaded=%0d want 1 0",
               tag, n_err, n_loaded);
    end
    n_chk++;
    if (sd_sec_read !== 1'b0 || write_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: read=%b wreq=%b want 0 0",
               tag, sd_sec_read, write_req);
    end
  endtask

  task automatic test_init_drop();
    bit got;
    int served;
    clear_obs();
    start_load(3, got);
    serve(1, 0, 301, served);
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (sd_sec_read !== 1'b0) begin
      n_fail++;
      $display("FAIL drop sec_read: got %b want 0", sd_sec_read);
    end
    repeat (20) @(negedge clk);
    n_chk++;
    if (pixq.size() != 82) begin
      n_fail++;
      $display("FAIL drop pix_count: got %0d want 82", pixq.size());
    end
    n_chk++;
    if (n_loaded != 0 || n_err != 0 || write_req !== 1'b0) begin
      n_fail++;
      $display("FAIL drop quiet: loaded=%0d err=%0d wreq=%b want 0 0 0",
               n_loaded, n_err, write_req);
    end
    sd_init_done = 1'b1;
    repeat (2) @(negedge clk);
    clear_obs();
    start_load(3, got);
    serve(2, 0, -1, served);
    repeat (10) @(negedge clk);
    n_chk++;
    if (served != 2 || sec_addrs.size() < 1 || sec_addrs[0] !== 32'(START)) begin
      n_fail++;
      $display("FAIL restart sectors: served=%0d want 2 from %0d", served, START);
    end
    check_image("restart");
  endtask

  task automatic test_ack_withheld();
    bit got;
    int served, bad;
    clear_obs();
    @(posedge clk); #1 photo_load = 1'b1;
    @(posedge clk); #1 photo_load = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (sd_sec_read !== 1'b0) bad++;
      photo_load = (i == 200 || i == 600);
    end
    photo_load = 1'b0;
    n_chk++;
    if (bad != 0 || write_req !== 1'b1) begin
      n_fail++;
      $display("FAIL hold: read_cycles=%0d wreq=%b want 0 1", bad, write_req);
    end
    @(posedge clk); #1 write_req_ack = 1'b1;
    @(posedge clk); #1 write_req_ack = 1'b0;
    serve(2, 0, -1, served);
    repeat (20) @(negedge clk);
    check_image("held");
    n_chk++;
    if (write_req !== 1'b0 || sd_sec_read !== 1'b0) begin
      n_fail++;
      $display("FAIL held relaunch: wreq=%b read=%b want 0 0",
               write_req, sd_sec_read);
    end
    got = 1'b0;
  endtask

  initial begin
    test_reset();
    test_valid_image();
    test_bad_header(1, "bad_sig");
    test_bad_header(2, "bad_height");
    test_init_drop();
    test_ack_withheld();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
